decode_stage: RTL

Parametrised successor of the single-cycle decode block for the RV64I+Zba pipeline. It decodes the instruction, reads a write-through register file, and owns the ID/EX pipeline register. It also detects load-use hazards against the instruction it already holds and inserts bubbles on its own, with valid/ready handshakes on both sides. It sits between the IF/ID register and the execute stage, and drives the execute stage directly from registered outputs.

---
 rtl/decode_pkg.sv | 93 +++++++++
 rtl/rf_bypass.sv | 39 +++
 rtl/decode_stage.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/decode_pkg.sv
// Shared decode types for the RV64I+Zba decode stage: opcodes, control encodings,
// the ID/EX register layout and the immediate generator.
package decode_pkg;

    localparam int unsigned XlenMax = 64;

    localparam logic [6:0] OpcLoad    = 7'b0000011;
    localparam logic [6:0] OpcOpImm   = 7'b0010011;
    localparam logic [6:0] OpcAuipc   = 7'b0010111;
    localparam logic [6:0] OpcOpImm32 = 7'b0011011;
    localparam logic [6:0] OpcStore   = 7'b0100011;
    localparam logic [6:0] OpcOp      = 7'b0110011;
    localparam logic [6:0] OpcLui     = 7'b0110111;
    localparam logic [6:0] OpcOp32    = 7'b0111011;
    localparam logic [6:0] OpcBranch  = 7'b1100011;
    localparam logic [6:0] OpcJalr    = 7'b1100111;
    localparam logic [6:0] OpcJal     = 7'b1101111;

    typedef enum logic [2:0] {ImmI, ImmS, ImmB, ImmU, ImmJ} imm_src_e;

    typedef enum logic [1:0] {
        ResAlu = 2'b00,
        ResMem = 2'b01,
        ResPc4 = 2'b10
    } result_src_e;

    typedef enum logic [3:0] {
        AluAdd    = 4'd0,
        AluSub    = 4'd1,
        AluSll    = 4'd2,
        AluSlt    = 4'd3,
        AluSltu   = 4'd4,
        AluXor    = 4'd5,
        AluSrl    = 4'd6,
        AluSra    = 4'd7,
        AluOr     = 4'd8,
        AluAnd    = 4'd9,
        AluSh1add = 4'd10,
        AluSh2add = 4'd11,
        AluSh3add = 4'd12,
        AluAdduw  = 4'd13
    } alu_op_e;

    // Data fields are sized for the widest datapath; narrower builds use the low bits.
    typedef struct packed {
        logic                 valid;
        logic [XlenMax-1:0]   rd1;
        logic [XlenMax-1:0]   rd2;
        logic [XlenMax-1:0]   imm;
        logic [XlenMax-1:0]   pc;
        logic [4:0]           rs1;
        logic [4:0]           rs2;
        logic [4:0]           rd;
        result_src_e          result_src;
        alu_op_e              alu_ctrl;
        logic                 mem_write;
        logic                 alu_src;
        logic                 reg_write;
        logic                 branch;
        logic                 jump;
        logic                 illegal;
    } id_ex_t;

    function automatic logic [31:0] imm_gen(input logic [31:7] instr, input imm_src_e src);
        logic [31:0] imm;
        case (src)
            ImmS:    imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            ImmB:    imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            ImmU:    imm = {instr[31:12], 12'b0};
            ImmJ:    imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21],
                            1'b0};
            default: imm = {{20{instr[31]}}, instr[31:20]};
        endcase
        return imm;
    endfunction

    function automatic alu_op_e base_alu(input logic [2:0] funct3, input logic f7b5,
                                         input logic is_rtype);
        alu_op_e op;
        case (funct3)
            3'b000:  op = (is_rtype && f7b5) ? AluSub : AluAdd;
            3'b001:  op = AluSll;
            3'b010:  op = AluSlt;
            3'b011:  op = AluSltu;
            3'b100:  op = AluXor;
            3'b101:  op = f7b5 ? AluSra : AluSrl;
            3'b110:  op = AluOr;
            default: op = AluAnd;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rf_bypass.sv
// 32 x XLEN register file: two asynchronous read ports, one write port, optional
// same-cycle write-to-read bypass. x0 reads zero and is never written.
module rf_bypass #(
    parameter int unsigned XLEN      = 64,
    parameter bit          RF_BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [4:0]      raddr1,
    input  logic [4:0]      raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);

    logic [XLEN-1:0] regs_q [32];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we && waddr != 5'd0) begin
            regs_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = regs_q[raddr1];
        rdata2 = regs_q[raddr2];
        if (RF_BYPASS && we && waddr == raddr1) rdata1 = wdata;
        if (RF_BYPASS && we && waddr == raddr2) rdata2 = wdata;
        if (raddr1 == 5'd0) rdata1 = '0;
        if (raddr2 == 5'd0) rdata2 = '0;
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: instruction decode, register read, load-use bubble insertion and the
// ID/EX pipeline register with valid/ready handshakes on both sides.
module decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned XLEN      = 64,
    parameter bit          ZBA_EN    = 1'b1,
    parameter bit          RF_BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     Instr_D,
    input  logic [XLEN-1:0] PC_D,
    input  logic [XLEN-1:0] Result_W,
    input  logic [4:0]      Rd_W,
    input  logic            RegWrite_W,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] RD1_E,
    output logic [XLEN-1:0] RD2_E,
    output logic [XLEN-1:0] ImmExt_E,
    output logic [XLEN-1:0] PC_E,
    output logic [4:0]      Rs1_E,
    output logic [4:0]      Rs2_E,
    output logic [4:0]      Rd_E,
    output logic [1:0]      ResultSrc_E,
    output logic [3:0]      ALUControl_E,
    output logic            MemWrite_E,
    output logic            ALUSrc_E,
    output logic            RegWrite_E,
    output logic            Branch_E,
    output logic            Jump_E,
    output logic            Illegal_E
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = Instr_D[6:0];
    assign funct3 = Instr_D[14:12];
    assign funct7 = Instr_D[31:25];

    logic        reg_write, mem_write, alu_src, branch, jump, illegal;
    logic        uses_rs1, uses_rs2, is_zba;
    result_src_e result_src;
    alu_op_e     alu_op;
    imm_src_e    imm_src;

    always_comb begin
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        alu_src    = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        illegal    = 1'b0;
        uses_rs1   = 1'b1;
        uses_rs2   = 1'b0;
        is_zba     = 1'b0;
        result_src = ResAlu;
        alu_op     = AluAdd;
        imm_src    = ImmI;
        case (opcode)
            OpcLoad: begin
                reg_write  = 1'b1;
                alu_src    = 1'b1;
                result_src = ResMem;
            end
            OpcStore: begin
                mem_write = 1'b1;
                alu_src   = 1'b1;
                imm_src   = ImmS;
                uses_rs2  = 1'b1;
            end
            OpcOp, OpcOp32: begin
                reg_write = 1'b1;
                uses_rs2  = 1'b1;
                alu_op    = base_alu(funct3, funct7[5], 1'b1);
                if (funct7 == 7'b0010000 && funct3 inside {3'b010, 3'b100, 3'b110}) begin
                    is_zba = 1'b1;
                    case (funct3[2:1])
                        2'b01:   alu_op = AluSh1add;
                        2'b10:   alu_op = AluSh2add;
                        default: alu_op = AluSh3add;
                    endcase
                end else if (opcode == OpcOp32 && funct7 == 7'b0000100 && funct3 == 3'b000) begin
                    is_zba = 1'b1;
                    alu_op = AluAdduw;
                end
                if (opcode == OpcOp32 && XLEN == 32) illegal = 1'b1;
            end
            OpcOpImm, OpcOpImm32: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                alu_op    = base_alu(funct3, funct7[5], 1'b0);
                if (opcode == OpcOpImm32 && XLEN == 32) illegal = 1'b1;
            end
            OpcBranch: begin
                branch   = 1'b1;
                imm_src  = ImmB;
                uses_rs2 = 1'b1;
                case (funct3[2:1])
                    2'b10:   alu_op = AluSlt;
                    2'b11:   alu_op = AluSltu;
                    default: alu_op = AluSub;
                endcase
            end
            OpcJal: begin
                jump       = 1'b1;
                reg_write  = 1'b1;
                result_src = ResPc4;
                imm_src    = ImmJ;
                uses_rs1   = 1'b0;
            end
            OpcJalr: begin
                jump       = 1'b1;
                reg_write  = 1'b1;
                result_src = ResPc4;
                alu_src    = 1'b1;
            end
            OpcLui, OpcAuipc: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                imm_src   = ImmU;
                uses_rs1  = 1'b0;
            end
            default: begin
                illegal  = 1'b1;
                uses_rs1 = 1'b0;
            end
        endcase
        if (is_zba && !ZBA_EN) illegal = 1'b1;
        if (illegal) begin
            reg_write = 1'b0;
            mem_write = 1'b0;
            branch    = 1'b0;
            jump      = 1'b0;
        end
    end

    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_ext;

    assign imm32 = imm_gen(Instr_D[31:7], imm_src);

    always_comb begin
        imm_ext       = {XLEN{imm32[31]}};
        imm_ext[31:0] = imm32;
    end

    // Unused source fields read as x0 so they never alias a forwarding or hazard match.
    logic [4:0]      rs1_addr, rs2_addr;
    logic [XLEN-1:0] rd1, rd2;

    assign rs1_addr = uses_rs1 ? Instr_D[19:15] : 5'd0;
    assign rs2_addr = uses_rs2 ? Instr_D[24:20] : 5'd0;

    rf_bypass #(
        .XLEN      (XLEN),
        .RF_BYPASS (RF_BYPASS)
    ) u_rf (
        .clk    (clk),
        .rst    (rst),
        .we     (RegWrite_W),
        .waddr  (Rd_W),
        .wdata  (Result_W),
        .raddr1 (rs1_addr),
        .raddr2 (rs2_addr),
        .rdata1 (rd1),
        .rdata2 (rd2)
    );

    id_ex_t e_q, e_d, dec;
    logic   hazard, adv;

    assign hazard = in_valid & e_q.valid & (e_q.result_src == ResMem) & (e_q.rd != 5'd0) &
                    ((uses_rs1 & (Instr_D[19:15] == e_q.rd)) |
                     (uses_rs2 & (Instr_D[24:20] == e_q.rd)));
    assign adv      = out_ready | ~e_q.valid;
    assign in_ready = flush | (~hazard & adv);

    always_comb begin
        dec            = '0;
        dec.valid      = in_valid;
        dec.rd1        = XlenMax'(rd1);
        dec.rd2        = XlenMax'(rd2);
        dec.imm        = XlenMax'(imm_ext);
        dec.pc         = XlenMax'(PC_D);
        dec.rs1        = rs1_addr;
        dec.rs2        = rs2_addr;
        dec.rd         = reg_write ? Instr_D[11:7] : 5'd0;
        dec.result_src = result_src;
        dec.alu_ctrl   = alu_op;
        dec.mem_write  = mem_write;
        dec.alu_src    = alu_src;
        dec.reg_write  = reg_write;
        dec.branch     = branch;
        dec.jump       = jump;
        dec.illegal    = illegal;
    end

    always_comb begin
        e_d = e_q;
        if (flush) begin
            e_d = '0;
        end else if (adv) begin
            e_d = hazard ? '0 : dec;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_q <= '0;
        end else begin
            e_q <= e_d;
        end
    end

    assign out_valid    = e_q.valid;
    assign RD1_E        = e_q.rd1[XLEN-1:0];
    assign RD2_E        = e_q.rd2[XLEN-1:0];
    assign ImmExt_E     = e_q.imm[XLEN-1:0];
    assign PC_E         = e_q.pc[XLEN-1:0];
    assign Rs1_E        = e_q.rs1;
    assign Rs2_E        = e_q.rs2;
    assign Rd_E         = e_q.rd;
    assign ResultSrc_E  = e_q.result_src;
    assign ALUControl_E = e_q.alu_ctrl;
    assign MemWrite_E   = e_q.mem_write;
    assign ALUSrc_E     = e_q.alu_src;
    assign RegWrite_E   = e_q.reg_write;
    assign Branch_E     = e_q.branch;
    assign Jump_E       = e_q.jump;
    assign Illegal_E    = e_q.illegal;

endmodule
